hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter STALL_CNT_W, default 16: width of o_stall_count.
REQ-002 Parameter MEM_TIMEOUT, default 255: maximum MEM_WAIT cycles before timeout is flagged.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_id_valid  in  1  ID stage holds a valid instruction.
REQ-006 i_id_uses_rs1, i_id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
REQ-007 i_id_rs1, i_id_rs2  in  5 each  ID source register fields.
REQ-008 i_ex_mem_r_en  in  1  EX instruction is a load.
REQ-009 i_ex_reg_dst  in  5  EX destination register.
REQ-010 i_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-011 i_mem_req  in  1  MEM stage is accessing data memory.
REQ-012 i_mem_ack  in  1  data memory completes the access this cycle.
REQ-013 i_cnt_clr  in  1  synchronous clear of o_stall_count.
REQ-014 o_pc_stall  out  1  hold PC.
REQ-015 o_if_id_stall  out  1  hold IF/ID register.
REQ-016 o_if_id_flush  out  1  load NOP into IF/ID.
REQ-017 o_id_ex_bubble  out  1  load NOP into ID/EX.
REQ-018 o_ex_mem_stall  out  1  hold ID/EX and EX/MEM, block MEM/WB update.
REQ-019 o_state  out  2  current FSM state: RUN=0, LOAD_USE=1, MEM_WAIT=2, FLUSH=3.
REQ-020 o_stall_count  out  STALL_CNT_W  saturating count of stall cycles.
REQ-021 o_mem_timeout  out  1  sticky error: MEM_WAIT exceeded MEM_TIMEOUT cycles.

Function
REQ-022 load_use SHALL be i_id_valid & i_ex_mem_r_en & (i_ex_reg_dst != 0) & ((i_id_uses_rs1 & i_id_rs1 == i_ex_reg_dst) | (i_id_uses_rs2 & i_id_rs2 == i_ex_reg_dst)).
REQ-023 mem_busy SHALL be i_mem_req & ~i_mem_ack.
REQ-024 Control outputs SHALL be combinational (Mealy) from the current inputs and registered state, with priority mem_busy > i_branch_taken > load_use.
REQ-025 mem_busy SHALL assert o_pc_stall, o_if_id_stall and o_ex_mem_stall, and deassert o_if_id_flush and o_id_ex_bubble.
REQ-026 i_branch_taken without mem_busy, in any state except FLUSH, SHALL assert o_if_id_flush and o_id_ex_bubble in the same cycle, with no stall outputs.
REQ-027 load_use without mem_busy or branch, in state RUN only, SHALL assert o_pc_stall, o_if_id_stall and o_id_ex_bubble for exactly that cycle.
REQ-028 In FLUSH, load_use and i_branch_taken SHALL be ignored, because the ID and EX contents are bubbles.
REQ-029 In LOAD_USE, load_use SHALL be ignored.
REQ-030 FSM transitions (evaluated each edge):
- Any state: next state is MEM_WAIT if mem_busy.
- Otherwise, next state is FLUSH if the branch was accepted (REQ-026).
- Otherwise, next state is LOAD_USE if the load_use stall was taken (REQ-027).
- Otherwise, next state is RUN.
REQ-031 MEM_WAIT exit: the cycle with i_mem_ack=1 SHALL drop all stalls in that same cycle, and the next state follows REQ-030.
REQ-032 A wait counter SHALL clear on entering MEM_WAIT and increment each cycle in MEM_WAIT.
REQ-033 When the wait counter reaches MEM_TIMEOUT, o_mem_timeout SHALL set and hold until reset; the stall SHALL continue.
REQ-034 o_stall_count SHALL increment by 1 on every cycle in which o_pc_stall=1 and saturate at all-ones.
REQ-035 i_cnt_clr SHALL take priority over the increment and set o_stall_count to 0 on the next edge.
REQ-036 Simultaneous i_mem_req=1 and i_mem_ack=1 in RUN SHALL cause no stall and no entry into MEM_WAIT.

Reset
REQ-037 i_rst_n=0 SHALL immediately force state RUN, o_stall_count=0, wait counter=0 and o_mem_timeout=0.
REQ-038 While i_rst_n=0, all five control outputs SHALL be 0 regardless of inputs.
REQ-039 Reset asserted mid-MEM_WAIT SHALL abort the wait; after release, state SHALL be RUN.

Verification
REQ-040 Load-use: EX lw x5, ID add x6,x5,x1 (uses_rs1) -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, state RUN->LOAD_USE->RUN, stall_count=1.
REQ-041 No hazard on x0: EX load with dst=0 and rs1=0 -> no stall outputs, state stays RUN.
REQ-042 Branch with hazard: branch_taken=1 and load_use=1 together -> flush=bubble=1, pc_stall=0; next cycle state FLUSH; a load_use repeated that cycle is ignored.
REQ-043 Memory wait: mem_req=1 with ack low for 3 cycles, then ack=1 -> ex_mem_stall=1 for 3 cycles, 0 on the ack cycle, stall_count=3.
REQ-044 Timeout: MEM_TIMEOUT=4 with ack held low 6 cycles -> o_mem_timeout=1 after the 4th wait cycle and sticky after ack; reset clears it.
REQ-045 Saturation/clear: STALL_CNT_W=2 with 5 stall cycles -> count 3; i_cnt_clr pulse during a stall -> count 0 on the next edge.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory wait
// stalls, with a saturating stall-cycle counter and a sticky memory-timeout flag.
module hazard_unit #(
    parameter int STALL_CNT_W = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_id_valid,
    input  logic                   i_id_uses_rs1,
    input  logic                   i_id_uses_rs2,
    input  logic [4:0]             i_id_rs1,
    input  logic [4:0]             i_id_rs2,
    input  logic                   i_ex_mem_r_en,
    input  logic [4:0]             i_ex_reg_dst,
    input  logic                   i_branch_taken,
    input  logic                   i_mem_req,
    input  logic                   i_mem_ack,
    input  logic                   i_cnt_clr,
    output logic                   o_pc_stall,
    output logic                   o_if_id_stall,
    output logic                   o_if_id_flush,
    output logic                   o_id_ex_bubble,
    output logic                   o_ex_mem_stall,
    output logic [1:0]             o_state,
    output logic [STALL_CNT_W-1:0] o_stall_count,
    output logic                   o_mem_timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LOAD_USE = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   timeout_q, timeout_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic load_use, mem_busy;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall;

    assign load_use = i_id_valid & i_ex_mem_r_en & (i_ex_reg_dst != 5'd0) &
                      ((i_id_uses_rs1 & (i_id_rs1 == i_ex_reg_dst)) |
                       (i_id_uses_rs2 & (i_id_rs2 == i_ex_reg_dst)));
    assign mem_busy = i_mem_req & ~i_mem_ack;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_stall = 1'b0;
        state_d      = ST_RUN;
        if (mem_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            state_d      = ST_MEM_WAIT;
        end else if (i_branch_taken && state_q != ST_FLUSH) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = ST_FLUSH;
        end else if (load_use && state_q == ST_RUN) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = ST_LOAD_USE;
        end
    end

    // Wait counter holds the number of busy cycles in the current wait, including this one.
    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if (mem_busy) begin
            if (state_q != ST_MEM_WAIT)
                wait_d = WAIT_W'(1);
            else if (wait_q < WAIT_W'(MEM_TIMEOUT))
                wait_d = wait_q + WAIT_W'(1);
            else
                wait_d = wait_q;
            if (wait_d == WAIT_W'(MEM_TIMEOUT))
                timeout_d = 1'b1;
        end
        cnt_d = cnt_q;
        if (i_cnt_clr)
            cnt_d = '0;
        else if (pc_stall && cnt_q != '1)
            cnt_d = cnt_q + STALL_CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Controls are forced low while reset is held, whatever the inputs are doing.
    assign o_pc_stall     = i_rst_n & pc_stall;
    assign o_if_id_stall  = i_rst_n & if_id_stall;
    assign o_if_id_flush  = i_rst_n & if_id_flush;
    assign o_id_ex_bubble = i_rst_n & id_ex_bubble;
    assign o_ex_mem_stall = i_rst_n & ex_mem_stall;
    assign o_state        = state_q;
    assign o_stall_count  = cnt_q;
    assign o_mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic, all compared against a behavioural model of the hazard rules.
module tb_hazard_unit;

    localparam int W  = 2;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         id_valid, uses_rs1, uses_rs2, ex_r_en, branch, mem_req, mem_ack, cnt_clr;
    logic [4:0]   rs1, rs2, ex_dst;
    logic         pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall, mem_timeout;
    logic [1:0]   state;
    logic [W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Model state: pipeline mode 0..3, stall count, busy-cycle length, sticky timeout.
    int m_state, m_cnt, m_wait, m_next;
    bit m_to;
    bit e_pc, e_ifs, e_flush, e_bub, e_exm;

    hazard_unit #(.STALL_CNT_W(W), .MEM_TIMEOUT(TO)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_valid     (id_valid),
        .i_id_uses_rs1  (uses_rs1),
        .i_id_uses_rs2  (uses_rs2),
        .i_id_rs1       (rs1),
        .i_id_rs2       (rs2),
        .i_ex_mem_r_en  (ex_r_en),
        .i_ex_reg_dst   (ex_dst),
        .i_branch_taken (branch),
        .i_mem_req      (mem_req),
        .i_mem_ack      (mem_ack),
        .i_cnt_clr      (cnt_clr),
        .o_pc_stall     (pc_stall),
        .o_if_id_stall  (if_id_stall),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_bubble (id_ex_bubble),
        .o_ex_mem_stall (ex_mem_stall),
        .o_state        (state),
        .o_stall_count  (stall_count),
        .o_mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit v, input bit u1, input bit u2, input int r1, input int r2,
                          input bit ld, input int dst, input bit br, input bit req,
                          input bit ack, input bit clr);
        id_valid = v;  uses_rs1 = u1; uses_rs2 = u2;
        rs1 = 5'(r1);  rs2 = 5'(r2);  ex_r_en = ld; ex_dst = 5'(dst);
        branch = br;   mem_req = req; mem_ack = ack; cnt_clr = clr;
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_wait = 0; m_to = 0;
    endtask

    task automatic model_outputs();
        bit lu, busy;
        lu = id_valid && ex_r_en && (ex_dst != 0) &&
             ((uses_rs1 && rs1 == ex_dst) || (uses_rs2 && rs2 == ex_dst));
        busy = mem_req && !mem_ack;
        {e_pc, e_ifs, e_flush, e_bub, e_exm} = '0;
        m_next = 0;
        if (rst_n) begin
            if (busy) begin
                e_pc = 1; e_ifs = 1; e_exm = 1; m_next = 2;
            end else if (branch && m_state != 3) begin
                e_flush = 1; e_bub = 1; m_next = 3;
            end else if (lu && m_state == 0) begin
                e_pc = 1; e_ifs = 1; e_bub = 1; m_next = 1;
            end
        end
    endtask

    task automatic check_all();
        model_outputs();
        chk("pc_stall",     pc_stall,     e_pc);
        chk("if_id_stall",  if_id_stall,  e_ifs);
        chk("if_id_flush",  if_id_flush,  e_flush);
        chk("id_ex_bubble", id_ex_bubble, e_bub);
        chk("ex_mem_stall", ex_mem_stall, e_exm);
        chk("state",        state,        m_state);
        chk("stall_count",  stall_count,  m_cnt);
        chk("mem_timeout",  mem_timeout,  m_to);
    endtask

    // One cycle: check outputs mid-cycle, take the edge, advance the model.
    task automatic tick();
        #2;
        check_all();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (mem_req && !mem_ack) begin
                m_wait = (m_state == 2) ? ((m_wait < TO) ? m_wait + 1 : TO) : 1;
                if (m_wait >= TO) m_to = 1;
            end else begin
                m_wait = 0;
            end
            if (cnt_clr)   m_cnt = 0;
            else if (e_pc) m_cnt = (m_cnt < (1 << W) - 1) ? m_cnt + 1 : m_cnt;
            m_state = m_next;
        end
        #1;
    endtask

    initial begin
        model_reset();
        // Reset held with hazardous inputs: controls must stay low.
        rst_n = 1'b0;
        set_in(1, 1, 1, 5, 5, 1, 5, 1, 1, 0, 0);
        @(posedge clk); #1;
        tick();
        tick();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        set_in(1, 1, 1, 5, 1, 1, 5, 0, 0, 0, 0);
        tick();
        chk("lu_state_after", state, 2'd1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("lu_count", stall_count, 1);

        // Load with x0 destination never stalls.
        set_in(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Branch together with a load-use hazard, hazard repeated in FLUSH.
        set_in(1, 1, 0, 7, 0, 1, 7, 1, 0, 0, 0);
        tick();
        chk("br_state_after", state, 2'd3);
        set_in(1, 1, 0, 7, 0, 1, 7, 1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Memory wait: three busy cycles then ack.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        chk("mw_count", stall_count, 3);
        chk("mw_no_timeout", mem_timeout, 0);

        // Simultaneous req and ack in RUN: no stall.
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();

        // Timeout: six busy cycles with a limit of four, then ack.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) tick();
        chk("to_before", mem_timeout, 0);
        tick();
        chk("to_after4", mem_timeout, 1);
        tick();
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("to_sticky", mem_timeout, 1);
        chk("saturated", stall_count, 3);

        // Clear pulse during a stall wins over the increment.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        chk("clr_in_stall", stall_count, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();

        // Reset asserted in the middle of a wait aborts it immediately.
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_state",   state,        0);
        chk("rst_count",   stall_count,  0);
        chk("rst_timeout", mem_timeout,  0);
        chk("rst_stall",   ex_mem_stall, 0);
        tick();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_rst_state", state, 0);

        // Random traffic with a narrow register range so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                   $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
